// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Time base and digit counter for the stopwatch datapath. A prescaler divides
// the system clock down to one centisecond. Each prescaler wrap advances a
// csec/sec/min digit chain, which wraps freely from 59:59.99 to 00:00.00.
// Counting pauses while i_run_on is low. While i_clr_on is high, everything is
// forced to zero. Every output comes straight from a register.
//
// Parameters:
//   CLK_HZ   system clock frequency in Hz
//   TICK_HZ  count rate in Hz (100 = one centisecond).
//            CLK_HZ / TICK_HZ must be at least 2.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   i_run_on     level: count while high, hold while low
//   i_clr_on     level: zero everything while high (wins over i_run_on)
//   o_csec       centiseconds 0..99
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_tick       one-cycle pulse, coincident with each new count value
//   o_rollover   one-cycle pulse on the 59:59.99 -> 00:00.00 wrap
//
// Optional feature, enabled by defining the macro STOPWATCH_LAP_EN:
//   i_lap        lap request level; a rising edge captures the digits
//   o_lap_csec   captured centiseconds
//   o_lap_sec    captured seconds
//   o_lap_min    captured minutes
//   o_lap_valid  high once a lap has been captured (cleared by clear/reset)
// -----------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_run_on,
   input  logic       i_clr_on,
   output logic [6:0] o_csec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic       o_tick,
   output logic       o_rollover
`ifdef STOPWATCH_LAP_EN
   ,
   input  logic       i_lap,
   output logic [6:0] o_lap_csec,
   output logic [5:0] o_lap_sec,
   output logic [5:0] o_lap_min,
   output logic       o_lap_valid
`endif
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   // ---------------------------------------------------------------------
   // Prescaler and digit chain
   // ---------------------------------------------------------------------
   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    csec_q,  csec_d;
   logic [5:0]    sec_q,   sec_d;
   logic [5:0]    min_q,   min_d;
   logic          tick_q,  tick_d;
   logic          roll_q,  roll_d;

   always_comb begin
      presc_d = presc_q;
      csec_d  = csec_q;
      sec_d   = sec_q;
      min_d   = min_q;
      tick_d  = 1'b0;
      roll_d  = 1'b0;

      if (i_clr_on) begin
         presc_d = '0;
         csec_d  = '0;
         sec_d   = '0;
         min_d   = '0;
      end else if (i_run_on) begin
         if (presc_q == PRESC_LAST) begin
            // Prescaler wrap: the new count value and its tick pulse
            // become visible together after this edge.
            presc_d = '0;
            tick_d  = 1'b1;
            if (csec_q == 7'd99) begin
               csec_d = '0;
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 6'd59) begin
                     min_d  = '0;
                     roll_d = 1'b1;
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end else begin
               csec_d = csec_q + 7'd1;
            end
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end
      // Pause: prescaler and digits hold, so the partial prescaler count
      // is kept and the next tick comes DIV - presc_q run cycles later.
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         csec_q  <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         tick_q  <= 1'b0;
         roll_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         csec_q  <= csec_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         tick_q  <= tick_d;
         roll_q  <= roll_d;
      end
   end

   assign o_csec     = csec_q;
   assign o_sec      = sec_q;
   assign o_min      = min_q;
   assign o_tick     = tick_q;
   assign o_rollover = roll_q;

`ifdef STOPWATCH_LAP_EN
   // ---------------------------------------------------------------------
   // Lap capture
   // ---------------------------------------------------------------------
   logic       lap_prev_q,  lap_prev_d;
   logic [6:0] lap_csec_q,  lap_csec_d;
   logic [5:0] lap_sec_q,   lap_sec_d;
   logic [5:0] lap_min_q,   lap_min_d;
   logic       lap_valid_q, lap_valid_d;

   always_comb begin
      // The previous value is still tracked during clear. A request
      // that rises while clear is high is therefore consumed there, and
      // does not fire later when clear drops.
      lap_prev_d  = i_lap;
      lap_csec_d  = lap_csec_q;
      lap_sec_d   = lap_sec_q;
      lap_min_d   = lap_min_q;
      lap_valid_d = lap_valid_q;

      if (i_clr_on) begin
         lap_csec_d  = '0;
         lap_sec_d   = '0;
         lap_min_d   = '0;
         lap_valid_d = 1'b0;
      end else if (i_lap && !lap_prev_q) begin
         // Capture the post-edge digits, so a tick on this same edge
         // is included in the lap time.
         lap_csec_d  = csec_d;
         lap_sec_d   = sec_d;
         lap_min_d   = min_d;
         lap_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lap_prev_q  <= 1'b0;
         lap_csec_q  <= '0;
         lap_sec_q   <= '0;
         lap_min_q   <= '0;
         lap_valid_q <= 1'b0;
      end else begin
         lap_prev_q  <= lap_prev_d;
         lap_csec_q  <= lap_csec_d;
         lap_sec_q   <= lap_sec_d;
         lap_min_q   <= lap_min_d;
         lap_valid_q <= lap_valid_d;
      end
   end

   assign o_lap_csec  = lap_csec_q;
   assign o_lap_sec   = lap_sec_q;
   assign o_lap_min   = lap_min_q;
   assign o_lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for stopwatch_counter (CLK_HZ=1000, TICK_HZ=100, DIV=10).
// The reference model keeps the elapsed time as one total number of
// centiseconds, plus a count of run cycles since the last tick. The expected
// digits are derived from that total with division and modulo.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int TOTAL_CS = 60 * 60 * 100;

   logic       clk;
   logic       reset;
   logic       run;
   logic       clr;
   logic       lap;
   logic [6:0] o_csec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic       o_tick;
   logic       o_rollover;
`ifdef STOPWATCH_LAP_EN
   logic [6:0] o_lap_csec;
   logic [5:0] o_lap_sec;
   logic [5:0] o_lap_min;
   logic       o_lap_valid;
`endif

   stopwatch_counter #(
      .CLK_HZ (CLK_HZ),
      .TICK_HZ(TICK_HZ)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_run_on  (run),
      .i_clr_on  (clr),
      .o_csec    (o_csec),
      .o_sec     (o_sec),
      .o_min     (o_min),
      .o_tick    (o_tick),
      .o_rollover(o_rollover)
`ifdef STOPWATCH_LAP_EN
      ,
      .i_lap      (lap),
      .o_lap_csec (o_lap_csec),
      .o_lap_sec  (o_lap_sec),
      .o_lap_min  (o_lap_min),
      .o_lap_valid(o_lap_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_total     = 0;   // elapsed centiseconds, 0..TOTAL_CS-1
   int m_phase     = 0;   // run cycles since the last tick
   int m_tick      = 0;
   int m_roll      = 0;
   int m_lap_total = 0;
   int m_lap_valid = 0;
   int m_lap_prev  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_total = 0; m_phase = 0; m_tick = 0; m_roll = 0;
         m_lap_total = 0; m_lap_valid = 0; m_lap_prev = 0;
      end else if (clr) begin
         m_total = 0; m_phase = 0; m_tick = 0; m_roll = 0;
         m_lap_total = 0; m_lap_valid = 0; m_lap_prev = int'(lap);
      end else begin
         m_tick = 0;
         m_roll = 0;
         if (run) begin
            m_phase++;
            if (m_phase == DIV) begin
               m_phase = 0;
               m_tick  = 1;
               m_total++;
               if (m_total == TOTAL_CS) begin
                  m_total = 0;
                  m_roll  = 1;
               end
            end
         end
         if (lap && m_lap_prev == 0) begin
            m_lap_total = m_total;
            m_lap_valid = 1;
         end
         m_lap_prev = int'(lap);
      end
   endtask

   task automatic compare_all();
      check("csec", int'(o_csec), m_total % 100);
      check("sec", int'(o_sec), (m_total / 100) % 60);
      check("min", int'(o_min), m_total / 6000);
      check("tick", int'(o_tick), m_tick);
      check("rollover", int'(o_rollover), m_roll);
`ifdef STOPWATCH_LAP_EN
      check("lap_csec", int'(o_lap_csec), m_lap_total % 100);
      check("lap_sec", int'(o_lap_sec), (m_lap_total / 100) % 60);
      check("lap_min", int'(o_lap_min), m_lap_total / 6000);
      check("lap_valid", int'(o_lap_valid), m_lap_valid);
`endif
   endtask

   // One clock edge: the model follows the same inputs, and the outputs are
   // sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int paused_ticks;
      reset = 1'b1;
      run   = 1'b0;
      clr   = 1'b0;
      lap   = 1'b0;

      // ---- Run from reset ----
      steps(2);
      check("reset_csec", int'(o_csec), 0);
      check("reset_tick", int'(o_tick), 0);
      reset = 1'b0;
      run   = 1'b1;
      steps(9);
      check("fresh_no_tick_before_div", int'(o_tick), 0);
      step();
      check("fresh_first_tick", int'(o_tick), 1);
      check("fresh_first_csec", int'(o_csec), 1);
      steps(990);
      check("fresh_1000_sec", int'(o_sec), 1);
      check("fresh_1000_csec", int'(o_csec), 0);
      $display("scenario run_from_reset: %0d:%0d.%0d", o_min, o_sec, o_csec);

      // ---- Pause ----
      run = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0; run = 1'b1;
      steps(15);
      run = 1'b0;
      paused_ticks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (o_tick) paused_ticks++;
      end
      check("pause_no_tick", paused_ticks, 0);
      check("pause_hold_csec", int'(o_csec), 1);
      run = 1'b1;
      steps(4);
      check("resume_no_early_tick", int'(o_tick), 0);
      step();
      check("resume_tick_after_5", int'(o_tick), 1);
      check("resume_csec", int'(o_csec), 2);
      $display("scenario pause: csec=%0d", o_csec);

      // ---- Clear priority ----
      run = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0; run = 1'b1;
      steps(370);
      check("clr_pre_csec", int'(o_csec), 37);
      clr = 1'b1;
      step();
      check("clr_csec", int'(o_csec), 0);
      check("clr_sec", int'(o_sec), 0);
      clr = 1'b0;
      steps(9);
      check("clr_no_early_tick", int'(o_tick), 0);
      step();
      check("clr_tick_after_10", int'(o_tick), 1);
      $display("scenario clear_priority: csec=%0d", o_csec);

      // ---- Rollover, using a backdoor load of 59:59.99 ----
      run = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0;
      force dut.csec_d = 7'd99;
      force dut.sec_d  = 6'd59;
      force dut.min_d  = 6'd59;
      @(posedge clk);
      #1;
      release dut.csec_d;
      release dut.sec_d;
      release dut.min_d;
      m_total = TOTAL_CS - 1;
      m_tick  = 0;
      m_roll  = 0;
      m_lap_prev = int'(lap);
      compare_all();
      run = 1'b1;
      steps(9);
      check("roll_no_early", int'(o_rollover), 0);
      step();
      check("roll_tick", int'(o_tick), 1);
      check("roll_pulse", int'(o_rollover), 1);
      check("roll_min", int'(o_min), 0);
      check("roll_csec", int'(o_csec), 0);
      step();
      check("roll_single_cycle", int'(o_rollover), 0);
      $display("scenario rollover: %0d:%0d.%0d", o_min, o_sec, o_csec);

      // ---- Mid-operation reset at 00:03.40, prescaler 6 ----
      run = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0; run = 1'b1;
      steps(3406);
      check("midrst_pre_sec", int'(o_sec), 3);
      check("midrst_pre_csec", int'(o_csec), 40);
      reset = 1'b1;
      step();
      check("midrst_sec", int'(o_sec), 0);
      check("midrst_csec", int'(o_csec), 0);
      reset = 1'b0;
      steps(9);
      check("midrst_no_early_tick", int'(o_tick), 0);
      step();
      check("midrst_tick_after_10", int'(o_tick), 1);
      $display("scenario mid_reset: csec=%0d", o_csec);

`ifdef STOPWATCH_LAP_EN
      // ---- Lap capture at 00:02.50 ----
      run = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0; run = 1'b1;
      steps(2500);
      lap = 1'b1;
      steps(20);
      lap = 1'b0;
      check("lap_valid_set", int'(o_lap_valid), 1);
      check("lap_sec_val", int'(o_lap_sec), 2);
      check("lap_csec_val", int'(o_lap_csec), 50);
      steps(30);
      check("lap_single_capture", int'(o_lap_csec), 50);
      check("lap_counting_continues", int'(o_csec), 55);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("lap_clr_valid", int'(o_lap_valid), 0);
      $display("scenario lap: done");
`endif

      // ---- Randomized run/clear/reset mix against the model ----
      for (int i = 0; i < 3000; i++) begin
         run   = ($urandom_range(0, 9) < 7);
         clr   = ($urandom_range(0, 199) < 3);
         reset = ($urandom_range(0, 499) < 1);
`ifdef STOPWATCH_LAP_EN
         lap   = ($urandom_range(0, 49) < 2) ? ~lap : lap;
`endif
         step();
      end
      reset = 1'b0; run = 1'b0; clr = 1'b0; lap = 1'b0;
      $display("scenario random: 3000 cycles, total_cs=%0d", m_total);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
